// File: rtl/dlx_bus_pkg.sv
// Shared types and constants for the DLX bus slave.
//   slv_state_e : FSM state encoding. Its values are visible on SLV_STATE_OUT.
//   xact_t      : the direction and write data of one bus transaction.
package dlx_bus_pkg;

  localparam int DW = 32;  // bus / RAM data width
  localparam int CW = 4;   // wait counter width (WAIT_STATES 0..15)

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_ACK     = 2'd2,
    S_RELEASE = 2'd3
  } slv_state_e;

  typedef struct packed {
    logic          we;    // 1 = write
    logic [DW-1:0] data;  // write data
  } xact_t;

endpackage

// File: rtl/dlx_bus_sram.sv
// Single-port synchronous word RAM (2**AW x DW). The read has one cycle of
// latency. The contents are not reset.
//   clk   : clock
//   en    : access enable
//   we    : 1 = write wdata to addr, 0 = read addr into rdata
//   addr  : word address
//   wdata : write data
//   rdata : read data, registered, updated only by reads
module dlx_bus_sram #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/dlx_bus_slave.sv
// Memory-side responder for the DLX AS_N/WR_N/ACK_N bus.
//   Bus side  : AS_N, WR_N, ADDR, DO (in); DI, ACK_N (out); SLV_STATE_OUT (debug)
//   Host side : host_req/we/addr/wdata (in); host_rdata, host_ack (out)
// The bus inputs are registered once, so the FSM acts one edge after the
// request is first sampled. A host access is taken only while the bus is
// quiet, which means an IDLE FSM, and AS_N high both in the sample register
// and on the pin. This lets a bus request that arrives together with a host
// request win.
module dlx_bus_slave
  import dlx_bus_pkg::*;
#(
  parameter int AW          = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          AS_N,
  input  logic          WR_N,
  input  logic [31:0]   ADDR,
  input  logic [31:0]   DO,
  output logic [31:0]   DI,
  output logic          ACK_N,
  output logic [1:0]    SLV_STATE_OUT,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [31:0]   host_wdata,
  output logic [31:0]   host_rdata,
  output logic          host_ack
);

  slv_state_e    state, nxt;
  logic          as_q;
  xact_t         smp_x, lat_x, cur_x;
  logic [AW-1:0] smp_addr, lat_addr, cur_addr;
  logic [CW-1:0] cnt;
  logic [DW-1:0] di_hold, hrd_hold, ram_rdata;
  logic          hrd_pend;
  logic          host_go, bus_rd, bus_wr;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;

  // The address bits above AW are ignored. This makes the index wrap modulo 2**AW.
  logic unused_addr_hi;
  assign unused_addr_hi = ^ADDR[31:AW];

  // Input sample stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      as_q     <= 1'b1;
      smp_x    <= '0;
      smp_addr <= '0;
    end else begin
      as_q     <= AS_N;
      smp_x    <= '{we: ~WR_N, data: DO};
      smp_addr <= ADDR[AW-1:0];
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:    if (!as_q) nxt = (WAIT_STATES == 0) ? S_ACK : S_WAIT;
      // An abort takes priority, even on the final wait cycle.
      S_WAIT:    if (as_q) nxt = S_IDLE;
                 else if (cnt <= CW'(1)) nxt = S_ACK;
      S_ACK:     nxt = S_RELEASE;
      S_RELEASE: if (as_q) nxt = S_IDLE;
      default:   nxt = S_IDLE;
    endcase
  end

  // With WAIT_STATES=0 the RAM read is issued on the accept edge. For that
  // case the access comes from the sample register rather than the latch.
  assign cur_x    = (state == S_IDLE) ? smp_x    : lat_x;
  assign cur_addr = (state == S_IDLE) ? smp_addr : lat_addr;

  assign host_go = (state == S_IDLE) && as_q && AS_N && host_req && !host_ack;
  assign bus_rd  = (nxt == S_ACK) && !cur_x.we;
  assign bus_wr  = (state == S_ACK) && lat_x.we;

  assign ram_en    = bus_rd | bus_wr | host_go;
  assign ram_we    = bus_wr | (host_go & host_we);
  assign ram_addr  = host_go ? host_addr  : cur_addr;
  assign ram_wdata = host_go ? host_wdata : lat_x.data;

  dlx_bus_sram #(.AW(AW), .DW(DW)) u_sram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      lat_x    <= '0;
      lat_addr <= '0;
      di_hold  <= '0;
      hrd_pend <= 1'b0;
      hrd_hold <= '0;
      host_ack <= 1'b0;
    end else begin
      state <= nxt;
      if (state == S_IDLE && !as_q) begin
        lat_x    <= smp_x;
        lat_addr <= smp_addr;
        cnt      <= CW'(WAIT_STATES);
      end else if (state == S_WAIT) begin
        cnt <= cnt - CW'(1);
      end
      if (state == S_ACK && !lat_x.we) di_hold <= ram_rdata;
      host_ack <= host_go;
      hrd_pend <= host_go && !host_we;
      if (hrd_pend) hrd_hold <= ram_rdata;
    end
  end

  // Read data appears straight from the RAM during the ACK cycle or the host
  // ack cycle. At all other times the last value is held.
  always_comb begin
    DI = di_hold;
    if (state == S_ACK && !lat_x.we) DI = ram_rdata;
  end

  assign host_rdata    = hrd_pend ? ram_rdata : hrd_hold;
  assign ACK_N         = (state != S_ACK);
  assign SLV_STATE_OUT = state;

endmodule

// File: tb/tb_dlx_bus_slave.sv
module tb_dlx_bus_slave;

  localparam int AW = 10;
  localparam int WS = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          AS_N = 1'b1, WR_N = 1'b1;
  logic [31:0]   ADDR = '0, DO = '0, DI;
  logic          ACK_N;
  logic [1:0]    st;
  logic          host_req = 1'b0, host_we = 1'b0, host_ack;
  logic [AW-1:0] host_addr = '0;
  logic [31:0]   host_wdata = '0, host_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dlx_bus_slave #(.AW(AW), .WAIT_STATES(WS)) dut (
    .clk(clk), .reset_n(reset_n), .AS_N(AS_N), .WR_N(WR_N), .ADDR(ADDR),
    .DO(DO), .DI(DI), .ACK_N(ACK_N), .SLV_STATE_OUT(st),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_ack(host_ack)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // One full bus handshake. The ACK must arrive WS+1 edges after the edge
  // that first samples AS_N=0. It must last one cycle, and the slave must then
  // return to idle.
  task automatic bus_xfer(input bit we, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd);
    int n;
    n = 0;
    @(posedge clk); #1;
    AS_N = 1'b0; WR_N = ~we; ADDR = a; DO = d;
    do begin @(posedge clk); #1; n++; end while (ACK_N && n < 20);
    chk("bus_latency", n - 1, WS + 1);
    rd = DI;
    AS_N = 1'b1;
    @(posedge clk); #1;
    chk("ack_width", {31'd0, ACK_N}, 1);
    n = 0;
    while (st != 2'd0 && n < 10) begin @(posedge clk); #1; n++; end
    chk("back_to_idle", {30'd0, st}, 0);
  endtask

  task automatic host_xfer(input bit we, input logic [AW-1:0] a, input logic [31:0] d,
                           output logic [31:0] rd);
    int n;
    n = 0;
    @(posedge clk); #1;
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    do begin @(posedge clk); #1; n++; end while (!host_ack && n < 30);
    chk("host_ack_seen", {31'd0, host_ack}, 1);
    rd = host_rdata;
    host_req = 1'b0;
  endtask

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t        tv [8];
  logic [31:0] ref_mem [16];
  logic [31:0] rd, a;
  int          ack_cyc, hack_cyc, acks, idx, op;
  logic [31:0] hrd;

  initial begin
    tv[0] = '{1'b1, 32'h0000_0100, 32'hAAAA_0001, 32'h0};
    tv[1] = '{1'b1, 32'hFFFF_F3FF, 32'h55AA_55AA, 32'h0};
    tv[2] = '{1'b0, 32'h0000_0100, 32'h0,         32'hAAAA_0001};
    tv[3] = '{1'b0, 32'h0000_03FF, 32'h0,         32'h55AA_55AA};
    tv[4] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0};
    tv[5] = '{1'b0, 32'h0000_0400, 32'h0,         32'h0000_0000};
    tv[6] = '{1'b1, 32'h8000_0801, 32'hC001_D00D, 32'h0};
    tv[7] = '{1'b0, 32'h0000_0001, 32'h0,         32'hC001_D00D};

    // Reset state
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack_n", {31'd0, ACK_N}, 1);
    chk("rst_di", DI, 0);
    chk("rst_state", {30'd0, st}, 0);
    chk("rst_host_ack", {31'd0, host_ack}, 0);
    chk("rst_host_rdata", host_rdata, 0);
    reset_n = 1'b1;

    // Host write, then a bus read of the same word
    host_xfer(1'b1, 10'd5, 32'hDEAD_BEEF, hrd);
    bus_xfer(1'b0, 32'd5, 32'd0, rd);
    chk("bus_rd_after_host_wr", rd, 32'hDEAD_BEEF);

    // Bus write with address wrap, then a host read-back
    bus_xfer(1'b1, 32'h0000_0407, 32'h1234_5678, rd);
    host_xfer(1'b0, 10'd7, 32'd0, hrd);
    chk("wrap_host_rd", hrd, 32'h1234_5678);

    // Table vectors
    for (int i = 0; i < 8; i++) begin
      bus_xfer(tv[i].we, tv[i].addr, tv[i].data, rd);
      if (!tv[i].we) chk($sformatf("tbl_rd[%0d]", i), rd, tv[i].exp);
    end

    // Abort: AS_N is raised after one WAIT cycle of a write
    host_xfer(1'b1, 10'd9, 32'h1111_1111, hrd);
    @(posedge clk); #1;
    AS_N = 1'b0; WR_N = 1'b0; ADDR = 32'd9; DO = 32'h9999_9999;
    @(posedge clk);
    @(posedge clk); #1;
    AS_N = 1'b1;
    acks = 0;
    repeat (8) begin @(posedge clk); #1; if (!ACK_N) acks++; end
    chk("abort_no_ack", acks, 0);
    chk("abort_idle", {30'd0, st}, 0);
    host_xfer(1'b0, 10'd9, 32'd0, hrd);
    chk("abort_mem_kept", hrd, 32'h1111_1111);

    // AS_N is held low after the ACK, then there is an immediate re-request
    host_xfer(1'b1, 10'd40, 32'h4040_4040, hrd);
    @(posedge clk); #1;
    AS_N = 1'b0; WR_N = 1'b1; ADDR = 32'd40;
    ack_cyc = 0;
    while (ACK_N && ack_cyc < 20) begin @(posedge clk); #1; ack_cyc++; end
    chk("hold_first_ack", {31'd0, ACK_N}, 0);
    chk("hold_first_di", DI, 32'h4040_4040);
    acks = 0;
    repeat (6) begin @(posedge clk); #1; if (!ACK_N) acks++; end
    chk("hold_no_second_ack", acks, 0);
    chk("hold_in_release", {30'd0, st}, 3);
    AS_N = 1'b1;
    bus_xfer(1'b0, 32'd40, 32'd0, rd);
    chk("rerequest_rd", rd, 32'h4040_4040);

    // host_req arrives while the bus is in WAIT. It is served only after
    // the bus has gone through RELEASE back to IDLE.
    @(posedge clk); #1;
    AS_N = 1'b0; WR_N = 1'b1; ADDR = 32'd5;
    @(posedge clk);
    @(posedge clk); #1;
    host_req = 1'b1; host_we = 1'b0; host_addr = 10'd7;
    ack_cyc = -1; hack_cyc = -1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (!ACK_N) begin ack_cyc = i; AS_N = 1'b1; end
      if (host_ack) begin hack_cyc = i; hrd = host_rdata; host_req = 1'b0; end
    end
    chk("pend_bus_ack_seen", (ack_cyc >= 0), 1);
    chk("pend_host_gap", hack_cyc - ack_cyc, 3);
    chk("pend_host_rd", hrd, 32'h1234_5678);

    // A bus request and host_req arrive in the same cycle, so the bus is served first
    host_xfer(1'b1, 10'd20, 32'hBBBB_0000, hrd);
    @(posedge clk); #1;
    AS_N = 1'b0; WR_N = 1'b1; ADDR = 32'd20;
    host_req = 1'b1; host_we = 1'b1; host_addr = 10'd20; host_wdata = 32'hAAAA_0000;
    ack_cyc = -1; hack_cyc = -1; rd = '0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (!ACK_N) begin ack_cyc = i; rd = DI; AS_N = 1'b1; end
      if (host_ack) begin hack_cyc = i; host_req = 1'b0; end
    end
    chk("tie_bus_rd_old", rd, 32'hBBBB_0000);
    chk("tie_bus_first", (ack_cyc >= 0 && hack_cyc > ack_cyc), 1);
    host_xfer(1'b0, 10'd20, 32'd0, hrd);
    chk("tie_host_wr_landed", hrd, 32'hAAAA_0000);

    // Randomised traffic against a plain array model
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      host_xfer(1'b1, AW'(i), ref_mem[i], hrd);
    end
    for (int k = 0; k < 40; k++) begin
      idx = $urandom_range(0, 15);
      op  = $urandom_range(0, 3);
      a   = $urandom;
      a[AW-1:0] = AW'(idx);
      case (op)
        0: begin ref_mem[idx] = $urandom; bus_xfer(1'b1, a, ref_mem[idx], rd); end
        1: begin bus_xfer(1'b0, a, 32'd0, rd); chk("rnd_bus_rd", rd, ref_mem[idx]); end
        2: begin ref_mem[idx] = $urandom; host_xfer(1'b1, AW'(idx), ref_mem[idx], hrd); end
        default: begin host_xfer(1'b0, AW'(idx), 32'd0, hrd); chk("rnd_host_rd", hrd, ref_mem[idx]); end
      endcase
    end

    // Reset in the middle of a write: the effect is immediate and the write is lost
    host_xfer(1'b1, 10'd30, 32'hCAFE_0000, hrd);
    bus_xfer(1'b0, 32'd30, 32'd0, rd);
    chk("pre_rst_di", DI, 32'hCAFE_0000);
    @(posedge clk); #1;
    AS_N = 1'b0; WR_N = 1'b0; ADDR = 32'd30; DO = 32'h0BAD_0BAD;
    @(posedge clk);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_ack_n", {31'd0, ACK_N}, 1);
    chk("midrst_di", DI, 0);
    chk("midrst_state", {30'd0, st}, 0);
    AS_N = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    host_xfer(1'b0, 10'd30, 32'd0, hrd);
    chk("midrst_write_lost", hrd, 32'hCAFE_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
